mem_port_arbiter: RTL

Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores). Holds a single outstanding transaction with a ready-based memory handshake and a timeout watchdog, and produces the fetch and memory-stage stall signals used by the hazard control unit. Sits between the pipeline stage registers and the external memory model.

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Single-outstanding-transaction arbiter sharing one memory port between
// instruction fetch and the data stage, with a timeout watchdog and stalls.
module mem_port_arbiter #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              flush_f,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [DATA_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              stall_f,
  output logic              stall_m,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err,
  output logic              err_sticky,
  output logic [1:0]        dbg_state
);

  // Memory handshake: mem_req rises with mem_addr/mem_we/mem_wdata and they
  // stay frozen until the first cycle mem_ready=1 (read data valid that same
  // cycle) or the watchdog fires; mem_req then drops for at least one cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    DM_WAIT = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              kill_q, kill_d;
  logic              mem_req_d, mem_we_d;
  logic [DATA_W-1:0] mem_addr_d, mem_wdata_d;
  logic              timeout;

  assign timeout   = (state_q != IDLE) && !mem_ready && (cnt_q == CNT_LAST);
  assign bus_err   = timeout;
  assign dbg_state = state_q;
  assign stall_m   = dm_req && !dm_done;
  assign stall_f   = (if_req && !if_valid) || (state_q != IDLE);

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      kill_q     <= 1'b0;
      err_sticky <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kill_q     <= kill_d;
      err_sticky <= err_sticky | timeout;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kill_d      = kill_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_valid    = 1'b0;
    if_rdata    = '0;
    dm_done     = 1'b0;
    dm_rdata    = '0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        kill_d = 1'b0;
        // Data first: it belongs to the older instruction.
        if (dm_req) begin
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          state_d     = DM_WAIT;
        end else if (if_req && !flush_f) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          state_d     = IF_WAIT;
        end
      end
      IF_WAIT: begin
        if (mem_ready || timeout) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          cnt_d     = '0;
          kill_d    = 1'b0;
          // A flushed fetch still finishes on the bus but is never delivered.
          if (!kill_q && !flush_f) begin
            if_valid = 1'b1;
            if_rdata = mem_ready ? mem_rdata : '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (flush_f) kill_d = 1'b1;
        end
      end
      DM_WAIT: begin
        if (mem_ready || timeout) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          cnt_d     = '0;
          dm_done   = 1'b1;
          dm_rdata  = mem_ready ? mem_rdata : '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
